// File: rtl/led_pwm_fader.sv
// Four-channel LED fader: ramps each channel's brightness toward its on/off target one step per
// step_tick and drives the LEDs with a 255-cycle PWM.
module led_pwm_fader #(
   parameter int unsigned CLK_FREQ     = 50_000_000,
   parameter int unsigned FADE_STEP_HZ = 1000
) (
   input  logic       clk_50mhz,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] led_in,
   input  logic [7:0] max_level,
   output logic [3:0] led_out,
   output logic [3:0] fading
);

   localparam int unsigned Div      = CLK_FREQ / FADE_STEP_HZ;
   localparam int unsigned PrescW   = (Div > 1) ? $clog2(Div) : 1;
   localparam logic [PrescW-1:0] PrescMax = PrescW'(Div - 1);

   typedef enum logic [1:0] {StOff, StRise, StOn, StFall} ch_state_e;

   logic [PrescW-1:0] presc_q, presc_d;
   logic              step_tick;
   logic [7:0]        pwm_cnt_q, pwm_cnt_d;
   logic [3:0]        led_q;
   logic [3:0][7:0]   level_q, level_d, target;
   ch_state_e         state [4];
   logic [3:0]        led_out_q, led_out_d;
   logic [3:0]        fading_q, fading_d;

   assign step_tick = (presc_q == PrescMax);
   assign presc_d   = step_tick ? '0 : presc_q + 1'b1;
   assign pwm_cnt_d = (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;

   // State register: level is the only per-channel memory; the FSM state is derived from it.
   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         presc_q   <= '0;
         pwm_cnt_q <= 8'd0;
         led_q     <= 4'b0000;
         level_q   <= '0;
         led_out_q <= 4'b0000;
         fading_q  <= 4'b0000;
      end else begin
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_d;
         led_q     <= led_in;
         level_q   <= level_d;
         led_out_q <= led_out_d;
         fading_q  <= fading_d;
      end
   end

   // Next-state: classify each channel from level vs target, then step the level on a tick.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         target[i] = led_q[i] ? max_level : 8'd0;
         if (level_q[i] < target[i]) begin
            state[i] = StRise;
         end else if (level_q[i] > target[i]) begin
            state[i] = StFall;
         end else if (target[i] == 8'd0) begin
            state[i] = StOff;
         end else begin
            state[i] = StOn;
         end

         level_d[i] = level_q[i];
         if (!enable) begin
            level_d[i] = 8'd0;
         end else if (step_tick) begin
            case (state[i])
               StRise:  level_d[i] = level_q[i] + 8'd1;
               StFall:  level_d[i] = level_q[i] - 8'd1;
               default: level_d[i] = level_q[i];
            endcase
         end
      end
   end

   // Outputs: both are registered and forced low the cycle after enable drops.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         fading_d[i]  = enable && ((state[i] == StRise) || (state[i] == StFall));
         led_out_d[i] = enable && (level_q[i] > pwm_cnt_q);
      end
   end

   assign led_out = led_out_q;
   assign fading  = fading_q;

endmodule
